axi_slave_sched: RTL and testbench

AXI_SLAVE_SCHED -- requirements
Module: axi_slave_sched

---
 rtl/axi_slave_sched_if.sv | 29 ++
 rtl/axi_slave_sched.sv | 111 +++++++++++
 tb/tb_axi_slave_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_sched_if.sv
// Groups the AR/AW address handshakes and the monitored R/B handshakes seen by axi_slave_sched.
// The slave modport is the scheduler's view; the master modport is the surrounding environment.
interface axi_slave_sched_if;
  logic arvalid_m;
  logic arready_m;
  logic awvalid_m;
  logic awready_m;
  logic arvalid_s;
  logic arready_s;
  logic awvalid_s;
  logic awready_s;
  logic rvalid_s;
  logic rready_s;
  logic rlast_s;
  logic bvalid_s;
  logic bready_s;

  modport slave (
    input  arvalid_m, awvalid_m, arready_s, awready_s,
    input  rvalid_s, rready_s, rlast_s, bvalid_s, bready_s,
    output arready_m, awready_m, arvalid_s, awvalid_s
  );

  modport master (
    output arvalid_m, awvalid_m, arready_s, awready_s,
    output rvalid_s, rready_s, rlast_s, bvalid_s, bready_s,
    input  arready_m, awready_m, arvalid_s, awvalid_s
  );
endinterface

// File: rtl/axi_slave_sched.sv
// Single-outstanding AR/AW scheduler in front of a 128-bit AXI slave; reads win unless a write is starved.
// Define AXI_SLAVE_SCHED_FAIR_EN to bound consecutive read grants to RD_BURST_MAX while a write waits.
module axi_slave_sched #(
  parameter int RD_BURST_MAX = 4
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst,
  axi_slave_sched_if.slave        bus,
  output logic                    sched_busy,
  output logic                    sched_grant_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;
  logic   w_forceWr;
  logic   w_idle;
  logic   w_selRd;
  logic   w_selWr;
  logic   w_rdGrant;
  logic   w_wrGrant;

  // Outputs are held low while reset is asserted, so IDLE only counts when out of reset.
  assign w_idle    = (r_state == IDLE) && !pad_cpu_rst;
  assign w_selRd   = bus.arvalid_m & ~w_forceWr;
  assign w_selWr   = bus.awvalid_m & ~w_selRd;
  assign w_rdGrant = w_idle & w_selRd & bus.arready_s;
  assign w_wrGrant = w_idle & w_selWr & bus.awready_s;

`ifdef AXI_SLAVE_SCHED_FAIR_EN
  logic [3:0] r_rdStreak;

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      r_rdStreak <= 4'd0;
    end else if (w_wrGrant) begin
      r_rdStreak <= 4'd0;
    end else if (w_rdGrant && bus.awvalid_m && (r_rdStreak != 4'(RD_BURST_MAX))) begin
      r_rdStreak <= r_rdStreak + 4'd1;
    end
  end

  assign w_forceWr = bus.awvalid_m & (r_rdStreak == 4'(RD_BURST_MAX));
`else
  assign w_forceWr = 1'b0;
`endif

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    bus.arvalid_s = 1'b0;
    bus.arready_m = 1'b0;
    bus.awvalid_s = 1'b0;
    bus.awready_m = 1'b0;
    sched_busy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!pad_cpu_rst) begin
          bus.arvalid_s = w_selRd;
          bus.arready_m = bus.arready_s & w_selRd;
          bus.awvalid_s = w_selWr;
          bus.awready_m = bus.awready_s & w_selWr;
        end
        if (w_rdGrant) begin
          w_stateNext = RD;
        end else if (w_wrGrant) begin
          w_stateNext = WR;
        end
      end
      RD: begin
        sched_busy = !pad_cpu_rst;
        // Only the final R beat closes the read; earlier beats pass through untouched.
        if (bus.rvalid_s && bus.rready_s && bus.rlast_s) begin
          w_stateNext = IDLE;
        end
      end
      WR: begin
        sched_busy = !pad_cpu_rst;
        if (bus.bvalid_s && bus.bready_s) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      sched_grant_wr <= 1'b0;
    end else if (w_wrGrant) begin
      sched_grant_wr <= 1'b1;
    end else if (w_rdGrant) begin
      sched_grant_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_slave_sched.sv
// Scoreboard bench for axi_slave_sched: directed stimulus pushes the expected grant type,
// a negedge monitor pops it whenever the scheduler hands an address to the slave.
module tb_axi_slave_sched;

  logic clk;
  logic rst;
  logic sched_busy;
  logic sched_grant_wr;
  int   nChecks;
  int   nFails;
  bit   expQ[$];
  logic pendCheck;
  logic pendVal;

  axi_slave_sched_if bus ();

  axi_slave_sched #(.RD_BURST_MAX(4)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .bus             (bus.slave),
    .sched_busy      (sched_busy),
    .sched_grant_wr  (sched_grant_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.arvalid_m = 1'b0;
    bus.awvalid_m = 1'b0;
    bus.arready_s = 1'b0;
    bus.awready_s = 1'b0;
    bus.rvalid_s  = 1'b0;
    bus.rready_s  = 1'b0;
    bus.rlast_s   = 1'b0;
    bus.bvalid_s  = 1'b0;
    bus.bready_s  = 1'b0;
  endtask

  // Drive one master/slave input pattern for the coming cycle.
  task automatic applyStimulus(input logic arv, input logic awv, input logic ars, input logic aws);
    bus.arvalid_m = arv;
    bus.awvalid_m = awv;
    bus.arready_s = ars;
    bus.awready_s = aws;
  endtask

  // Monitor: every address handshake toward the slave consumes one scoreboard entry,
  // and the registered grant flag is checked on the following cycle.
  always @(negedge clk) begin
    if (pendCheck) begin
      checkOutput("sched_grant_wr_after_grant", sched_grant_wr, pendVal);
      pendCheck = 1'b0;
    end
    if (!rst && ((bus.arvalid_s && bus.arready_s) || (bus.awvalid_s && bus.awready_s))) begin
      logic got;
      logic exp;
      got = (bus.awvalid_s && bus.awready_s) ? 1'b1 : 1'b0;
      checkOutput("ar_aw_exclusive", bus.arvalid_s & bus.awvalid_s, 1'b0);
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_grant: got grant_wr=%b, expected no grant at %0t", got, $time);
      end else begin
        exp = expQ.pop_front();
        checkOutput("grant_type", got, exp);
        if (exp) checkOutput("awready_m_on_grant", bus.awready_m, 1'b1);
        else     checkOutput("arready_m_on_grant", bus.arready_m, 1'b1);
        pendCheck = 1'b1;
        pendVal   = exp;
      end
    end
  end

  initial begin
    bit fairSeq[6];
    nChecks   = 0;
    nFails    = 0;
    pendCheck = 1'b0;
    pendVal   = 1'b0;
    clearInputs();
    rst = 1'b1;
    step();
    step();

    // Outputs stay low in reset even with a requesting master.
    bus.arvalid_m = 1'b1;
    bus.arready_s = 1'b1;
    @(negedge clk);
    checkOutput("rst_arvalid_s", bus.arvalid_s, 1'b0);
    checkOutput("rst_arready_m", bus.arready_m, 1'b0);
    checkOutput("rst_busy", sched_busy, 1'b0);
    checkOutput("rst_grant_wr", sched_grant_wr, 1'b0);
    step();
    clearInputs();
    rst = 1'b0;
    step();

    // Four-beat read: busy for exactly the four RD cycles.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expQ.push_back(1'b0);
    @(negedge clk);
    checkOutput("rd_idle_arvalid_s", bus.arvalid_s, 1'b1);
    checkOutput("rd_idle_busy", sched_busy, 1'b0);
    step();
    clearInputs();
    for (int b = 0; b < 4; b++) begin
      bus.rvalid_s = 1'b1;
      bus.rready_s = 1'b1;
      bus.rlast_s  = (b == 3);
      @(negedge clk);
      checkOutput("rd_beat_busy", sched_busy, 1'b1);
      step();
    end
    clearInputs();
    @(negedge clk);
    checkOutput("rd_done_busy", sched_busy, 1'b0);
    step();

    // Simultaneous requests: read wins.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    expQ.push_back(1'b0);
    @(negedge clk);
    checkOutput("both_arvalid_s", bus.arvalid_s, 1'b1);
    checkOutput("both_awvalid_s", bus.awvalid_s, 1'b0);
    checkOutput("both_awready_m", bus.awready_m, 1'b0);
    step();
    clearInputs();
    bus.rvalid_s = 1'b1;
    bus.rready_s = 1'b1;
    bus.rlast_s  = 1'b1;
    step();
    clearInputs();
    step();

    // Write with a stalled B channel; address outputs stay quiet while busy.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    expQ.push_back(1'b1);
    @(negedge clk);
    checkOutput("wr_awvalid_s", bus.awvalid_s, 1'b1);
    checkOutput("wr_awready_m", bus.awready_m, 1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("wr_busy_arvalid_s", bus.arvalid_s, 1'b0);
    checkOutput("wr_busy_awvalid_s", bus.awvalid_s, 1'b0);
    checkOutput("wr_busy_arready_m", bus.arready_m, 1'b0);
    checkOutput("wr_busy_awready_m", bus.awready_m, 1'b0);
    step();
    clearInputs();
    for (int c = 0; c < 3; c++) begin
      bus.bvalid_s = 1'b1;
      bus.bready_s = 1'b0;
      @(negedge clk);
      checkOutput("wr_bstall_busy", sched_busy, 1'b1);
      step();
    end
    bus.bvalid_s = 1'b1;
    bus.bready_s = 1'b1;
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("wr_done_busy", sched_busy, 1'b0);
    checkOutput("wr_done_grant_wr_held", sched_grant_wr, 1'b1);
    step();

    // Master withdraws before the slave is ready: no state change.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_arvalid_s", bus.arvalid_s, 1'b1);
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("drop_busy", sched_busy, 1'b0);
    checkOutput("drop_grant_wr", sched_grant_wr, 1'b1);
    step();

    // Both masters held high: fair build inserts a write after four reads.
`ifdef AXI_SLAVE_SCHED_FAIR_EN
    fairSeq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    fairSeq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      bus.rvalid_s = 1'b0; bus.rready_s = 1'b0; bus.rlast_s = 1'b0;
      bus.bvalid_s = 1'b0; bus.bready_s = 1'b0;
      expQ.push_back(fairSeq[i]);
      step();
      if (fairSeq[i]) begin
        bus.bvalid_s = 1'b1; bus.bready_s = 1'b1;
      end else begin
        bus.rvalid_s = 1'b1; bus.rready_s = 1'b1; bus.rlast_s = 1'b1;
      end
      step();
    end
    clearInputs();
    step();

    // Reset during the second R beat abandons the read.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expQ.push_back(1'b0);
    step();
    clearInputs();
    bus.rvalid_s = 1'b1;
    bus.rready_s = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_busy_low", sched_busy, 1'b0);
    step();
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("post_rst_busy", sched_busy, 1'b0);
    checkOutput("post_rst_grant_wr", sched_grant_wr, 1'b0);
`ifdef AXI_SLAVE_SCHED_FAIR_EN
    checkOutput("post_rst_streak_zero", dut.r_rdStreak == 4'd0, 1'b1);
`endif
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    expQ.push_back(1'b0);
    @(negedge clk);
    checkOutput("post_rst_arvalid_s", bus.arvalid_s, 1'b1);
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("post_rst_rd_busy", sched_busy, 1'b1);
    step();
    bus.rvalid_s = 1'b1;
    bus.rready_s = 1'b1;
    bus.rlast_s  = 1'b1;
    step();
    clearInputs();
    step();
    step();

    checkOutput("scoreboard_drained", expQ.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
